rn_w_route: RTL and testbench
=============================

// Module: rn_w_route
// PURPOSE
//  Downstream W-channel steering stage for the RN write path. Takes AXI W beats from the RN
//  port, together with the per-beat target ID produced by the RN write tracker, and routes
//  each beat into one of NUM_TGT per-target FIFOs that feed the NoC injection ports.
//  The target is locked for a whole burst (first beat to WLAST), so no burst is split
//  across targets. Per-target buffering isolates a stalled target from the other targets'
//  drain.
// PARAMETERS
//  DATA_WIDTH  128  W data width in bits; WSTRB width = DATA_WIDTH/8
//  ID_WIDTH    11   WID width
//  NUM_TGT     4    number of target ports; fixed by the 2-bit target ID
//  FIFO_DEPTH  4    entries per target FIFO; power of 2, >= 2
// PORTS
//  clk          in   1                    clock
//  rst          in   1                    reset, synchronous, active-high
//  s_wvalid     in   1                    RN W beat valid
//  s_wready     out  1                    RN W beat ready
//  s_wid        in   ID_WIDTH             beat ID
//  s_wdata      in   DATA_WIDTH           beat data
//  s_wstrb      in   DATA_WIDTH/8         byte strobes
//  s_wlast      in   1                    last beat of burst
//  w_tgtid      in   2                    target ID from write tracker; valid with s_wvalid
//  m_wvalid     out  NUM_TGT              per-target beat valid
//  m_wready     in   NUM_TGT              per-target beat ready
//  m_wid        out  NUM_TGT*ID_WIDTH     per-target ID; slice t = [t*ID_WIDTH +: ID_WIDTH]
//  m_wdata      out  NUM_TGT*DATA_WIDTH   per-target data, packed as for m_wid
//  m_wstrb      out  NUM_TGT*DATA_WIDTH/8 per-target strobes, packed as for m_wid
//  m_wlast      out  NUM_TGT              per-target last
//  burst_active out  1                    1 between first accepted beat and accepted WLAST
//  err_tgt_sw   out  1                    sticky: target ID changed mid-burst
// BEHAVIOUR
//  - Reset values:
//    - all FIFOs empty; pointers 0; m_wvalid = 0; burst_active = 0; err_tgt_sw = 0.
//    - locked_tgt = 0.
//    - m_wid/m_wdata/m_wstrb/m_wlast = 0.
//  - Target select: sel = burst_active ? locked_tgt : w_tgtid.
//  - Ready and accept:
//    - s_wready = ~full[sel]. Combinational from registered state and w_tgtid.
//    - Accept = s_wvalid & s_wready.
//  - Burst lock:
//    - Accepted beat with burst_active = 0 and s_wlast = 0: locked_tgt <= w_tgtid,
//      burst_active <= 1.
//    - Accepted beat with s_wlast = 1: burst_active <= 0. A single-beat burst never sets
//      burst_active.
//  - Mid-burst target mismatch:
//    - Condition: accepted beat, burst_active = 1, w_tgtid != locked_tgt.
//    - Beat still goes to locked_tgt. err_tgt_sw <= 1, held until rst.
//  - FIFO per target:
//    - Entry = {id, data, strb, last}.
//    - Push on accept when sel == t. Pop on m_wvalid[t] & m_wready[t].
//    - m_wvalid[t] = ~empty[t]; m_* slices = head entry.
//    - Latency: beat accepted in cycle N is visible on m_w* in cycle N+1. No same-cycle
//      bypass.
//    - Occupancy counter 0..FIFO_DEPTH, width $clog2(FIFO_DEPTH)+1.
//    - Pointers wrap modulo FIFO_DEPTH.
//  - Boundary conditions:
//    - full[t] = (count == FIFO_DEPTH). When full, s_wready = 0 for sel == t, even if
//      m_wready[t] = 1 that cycle (no pop-through).
//    - Push and pop in the same cycle on a non-full, non-empty FIFO: count unchanged, head
//      advances.
//    - Empty: pop is impossible (m_wvalid = 0).
//    - m_w* held stable while m_wvalid[t] & ~m_wready[t].
//  - Blocking: a burst to a full target stalls s_wready. Other FIFOs keep draining
//    independently.
//  - rst mid-operation: all FIFO contents discarded; state returns to reset values next
//    cycle; no partial beat is emitted.
// TESTING
//  - Single-beat burst: s_wid=0x12, tgt=2, wlast=1, all m_wready=1 -> m_wvalid=4'b0100 one
//    cycle later, m_wid[2]=0x12, m_wlast[2]=1, burst_active stays 0.
//  - 6-beat burst to tgt 1, m_wready[1]=0 -> 4 beats accepted, s_wready=0 from the 5th beat.
//    Raise m_wready[1] -> remaining 2 beats accepted, in order. m_wlast[1] only on beat 6.
//  - 3-beat burst starting at tgt 3, w_tgtid=0 on beat 2 -> all 3 beats on port 3,
//    err_tgt_sw=1 and held.
//  - FIFO 0 full with m_wready[0]=1 and s_wvalid to tgt 0 -> no accept that cycle, count 4->3.
//    Next cycle accepted, count 3->4.
//  - Tgt 0 stalled and full, burst to tgt 0 blocked. FIFO 3 holding 2 beats with
//    m_wready[3]=1 -> port 3 drains both beats while s_wready stays 0.
//  - rst asserted after beat 2 of a 4-beat burst to tgt 1 -> next cycle m_wvalid=0,
//    burst_active=0, err_tgt_sw=0. A new burst to tgt 2 then routes normally.

Source files
------------

// File: rtl/rn_w_route_if.sv
// W-channel bundle for the RN write steering stage: the RN-side beat
// handshake (with its tracker target ID) and the per-target output ports.
interface rn_w_route_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 11,
  parameter int NUM_TGT    = 4
);
  logic                            s_wvalid;
  logic                            s_wready;
  logic [ID_WIDTH-1:0]             s_wid;
  logic [DATA_WIDTH-1:0]           s_wdata;
  logic [DATA_WIDTH/8-1:0]         s_wstrb;
  logic                            s_wlast;
  logic [1:0]                      w_tgtid;
  logic [NUM_TGT-1:0]              m_wvalid;
  logic [NUM_TGT-1:0]              m_wready;
  logic [NUM_TGT*ID_WIDTH-1:0]     m_wid;
  logic [NUM_TGT*DATA_WIDTH-1:0]   m_wdata;
  logic [NUM_TGT*DATA_WIDTH/8-1:0] m_wstrb;
  logic [NUM_TGT-1:0]              m_wlast;

  // Steering-stage view: consumes RN beats, produces per-target beats.
  modport slave (
    input  s_wvalid, s_wid, s_wdata, s_wstrb, s_wlast, w_tgtid, m_wready,
    output s_wready, m_wvalid, m_wid, m_wdata, m_wstrb, m_wlast
  );

  // Environment view: drives RN beats, sinks per-target beats.
  modport master (
    output s_wvalid, s_wid, s_wdata, s_wstrb, s_wlast, w_tgtid, m_wready,
    input  s_wready, m_wvalid, m_wid, m_wdata, m_wstrb, m_wlast
  );
endinterface

// File: rtl/rn_w_route.sv
// RN write-path W steering: routes each accepted beat into a per-target FIFO,
// locking the target for a whole burst so no burst is split across targets.
module rn_w_route #(
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 11,
  parameter int NUM_TGT    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  rn_w_route_if.slave  bus,
  output logic         burst_active,
  output logic         err_tgt_sw
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_W-1:0]     strb;
    logic                  last;
  } entry_t;

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  entry_t             mem    [NUM_TGT][FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr [NUM_TGT];
  logic [PTR_W-1:0]   rd_ptr [NUM_TGT];
  logic [CNT_W-1:0]   count  [NUM_TGT];
  logic [NUM_TGT-1:0] full, empty, push, pop;
  logic [1:0]         locked_tgt, sel;
  logic               s_wready_int, accept;
  state_t             state;
  entry_t             in_entry;

  // Target select, FIFO status and the input handshake.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch or loop, so no latch can be inferred.
    full  = '0;
    empty = '0;
    push  = '0;
    pop   = '0;
    sel   = burst_active ? locked_tgt : bus.w_tgtid;
    for (int t = 0; t < NUM_TGT; t++) begin
      full[t]  = (count[t] == CNT_W'(FIFO_DEPTH));
      empty[t] = (count[t] == '0);
    end
    s_wready_int = ~full[sel];
    accept       = bus.s_wvalid & s_wready_int;
    for (int t = 0; t < NUM_TGT; t++) begin
      push[t] = accept && (int'(sel) == t);
      pop[t]  = ~empty[t] & bus.m_wready[t];
    end
    in_entry = '{id: bus.s_wid, data: bus.s_wdata, strb: bus.s_wstrb, last: bus.s_wlast};
  end

  assign bus.s_wready = s_wready_int;

  // Present each FIFO head; an empty FIFO shows all zeros.
  always_comb begin
    entry_t head;
    head         = '0;
    bus.m_wvalid = ~empty;
    bus.m_wid    = '0;
    bus.m_wdata  = '0;
    bus.m_wstrb  = '0;
    bus.m_wlast  = '0;
    for (int t = 0; t < NUM_TGT; t++) begin
      head = empty[t] ? '0 : mem[t][rd_ptr[t]];
      bus.m_wid[t*ID_WIDTH +: ID_WIDTH]     = head.id;
      bus.m_wdata[t*DATA_WIDTH +: DATA_WIDTH] = head.data;
      bus.m_wstrb[t*STRB_W +: STRB_W]       = head.strb;
      bus.m_wlast[t]                        = head.last;
    end
  end

  // FIFO storage write.
  // NOTE: storage has no reset; the counters define validity and empty heads are masked to zero.
  always_ff @(posedge clk) begin
    for (int t = 0; t < NUM_TGT; t++) begin
      if (push[t]) mem[t][wr_ptr[t]] <= in_entry;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every reader sees the pre-edge value.
    if (rst) begin
      for (int t = 0; t < NUM_TGT; t++) begin
        wr_ptr[t] <= '0;
        rd_ptr[t] <= '0;
        count[t]  <= '0;
      end
    end else begin
      for (int t = 0; t < NUM_TGT; t++) begin
        if (push[t]) wr_ptr[t] <= wr_ptr[t] + 1'b1;
        if (pop[t])  rd_ptr[t] <= rd_ptr[t] + 1'b1;
        case ({push[t], pop[t]})
          2'b10:   count[t] <= count[t] + CNT_W'(1);
          2'b01:   count[t] <= count[t] - CNT_W'(1);
          default: count[t] <= count[t];
        endcase
      end
    end
  end

  // Burst lock FSM: holds the target from first beat to WLAST and flags target switches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      burst_active <= 1'b0;
      locked_tgt   <= '0;
      err_tgt_sw   <= 1'b0;
    end else if (accept) begin
      if (state == ST_BURST && bus.w_tgtid != locked_tgt) err_tgt_sw <= 1'b1;
      if (bus.s_wlast) begin
        state        <= ST_IDLE;
        burst_active <= 1'b0;
      end else if (state == ST_IDLE) begin
        state        <= ST_BURST;
        burst_active <= 1'b1;
        locked_tgt   <= bus.w_tgtid;
      end
    end
  end
endmodule

// File: tb/tb_rn_w_route.sv
// Self-checking bench for rn_w_route: directed scenarios plus a random mix,
// with a per-target scoreboard of expected beats.
module tb_rn_w_route;
  localparam int DW = 128;
  localparam int IW = 11;
  localparam int NT = 4;
  localparam int SW = DW / 8;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          last;
  } beat_t;

  logic clk;
  logic rst;
  logic burst_active;
  logic err_tgt_sw;

  rn_w_route_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .NUM_TGT(NT)) bus ();

  rn_w_route #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .NUM_TGT(NT), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .burst_active (burst_active),
    .err_tgt_sw   (err_tgt_sw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  beat_t exp_q [NT][$];
  logic       m_active = 1'b0;
  logic [1:0] m_locked = 2'd0;
  logic       m_err    = 1'b0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: samples mid-cycle what the next rising edge will do.
  always @(negedge clk) begin : mon
    logic [1:0]    msel;
    logic [NT-1:0] mv;
    beat_t         head;
    if (rst) begin
      for (int t = 0; t < NT; t++) exp_q[t].delete();
      m_active = 1'b0;
      m_locked = 2'd0;
      m_err    = 1'b0;
    end else begin
      for (int t = 0; t < NT; t++) mv[t] = (exp_q[t].size() != 0);
      check("m_wvalid", bus.m_wvalid, mv);
      check("burst_active", burst_active, m_active);
      check("err_tgt_sw", err_tgt_sw, m_err);
      msel = m_active ? m_locked : bus.w_tgtid;
      if (bus.s_wvalid) check("s_wready", bus.s_wready, exp_q[msel].size() != DEPTH);
      for (int t = 0; t < NT; t++) begin
        if (bus.m_wvalid[t] && exp_q[t].size() != 0) begin
          head = '{id: bus.m_wid[t*IW +: IW], data: bus.m_wdata[t*DW +: DW],
                   strb: bus.m_wstrb[t*SW +: SW], last: bus.m_wlast[t]};
          check($sformatf("head_t%0d", t), head, exp_q[t][0]);
          if (bus.m_wready[t]) void'(exp_q[t].pop_front());
        end
      end
      if (bus.s_wvalid && bus.s_wready) begin
        exp_q[msel].push_back('{id: bus.s_wid, data: bus.s_wdata, strb: bus.s_wstrb,
                                last: bus.s_wlast});
        if (m_active && bus.w_tgtid != m_locked) m_err = 1'b1;
        if (bus.s_wlast) m_active = 1'b0;
        else if (!m_active) begin
          m_active = 1'b1;
          m_locked = bus.w_tgtid;
        end
      end
    end
  end

  task automatic drive_beat(input logic [IW-1:0] id, input logic [DW-1:0] data,
                            input logic [SW-1:0] strb, input logic last, input logic [1:0] tgt);
    bus.s_wid    = id;
    bus.s_wdata  = data;
    bus.s_wstrb  = strb;
    bus.s_wlast  = last;
    bus.w_tgtid  = tgt;
    bus.s_wvalid = 1'b1;
  endtask

  // Holds the current beat until accepted; returns #1 after the accepting edge.
  task automatic wait_accept();
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = bus.s_wready;
      @(posedge clk);
      #1;
    end
    if (!ok) check("accept_timeout", 1'b0, 1'b1);
    bus.s_wvalid = 1'b0;
  endtask

  task automatic send_beat(input logic [IW-1:0] id, input logic [DW-1:0] data,
                           input logic [SW-1:0] strb, input logic last, input logic [1:0] tgt);
    drive_beat(id, data, strb, last, tgt);
    wait_accept();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  bit rnd_done = 1'b0;

  initial begin
    rst          = 1'b1;
    bus.s_wvalid = 1'b0;
    bus.s_wid    = '0;
    bus.s_wdata  = '0;
    bus.s_wstrb  = '0;
    bus.s_wlast  = 1'b0;
    bus.w_tgtid  = 2'd0;
    bus.m_wready = '1;
    idle(3);
    rst = 1'b0;
    idle(1);

    // Reset state.
    check("rst_m_wvalid", bus.m_wvalid, 4'b0000);
    check("rst_s_wready", bus.s_wready, 1'b1);
    check("rst_burst_active", burst_active, 1'b0);
    check("rst_err", err_tgt_sw, 1'b0);
    check("rst_m_wid", bus.m_wid, '0);

    // Single-beat burst to target 2.
    send_beat(11'h012, {4{32'hA5A5_0001}}, 16'hFFFF, 1'b1, 2'd2);
    check("single_m_wvalid", bus.m_wvalid, 4'b0100);
    check("single_m_wid2", bus.m_wid[2*IW +: IW], 11'h012);
    check("single_m_wlast2", bus.m_wlast[2], 1'b1);
    check("single_burst_active", burst_active, 1'b0);
    idle(3);

    // 6-beat burst into a stalled target 1: four fit, the fifth stalls.
    bus.m_wready = 4'b1101;
    for (int b = 0; b < 4; b++)
      send_beat(11'h100 + IW'(b), {4{32'(b + 10)}}, 16'h00FF, 1'b0, 2'd1);
    drive_beat(11'h104, {4{32'd14}}, 16'h0F0F, 1'b0, 2'd1);
    idle(1);
    check("stall_s_wready_a", bus.s_wready, 1'b0);
    idle(1);
    check("stall_s_wready_b", bus.s_wready, 1'b0);
    bus.m_wready = 4'b1111;
    wait_accept();
    send_beat(11'h105, {4{32'd15}}, 16'hF0F0, 1'b1, 2'd1);
    idle(8);

    // Mid-burst target switch: beats stay on port 3, error becomes sticky.
    send_beat(11'h030, {4{32'h3000_0000}}, 16'h1111, 1'b0, 2'd3);
    send_beat(11'h031, {4{32'h3000_0001}}, 16'h2222, 1'b0, 2'd0);
    send_beat(11'h032, {4{32'h3000_0002}}, 16'h3333, 1'b1, 2'd3);
    check("switch_err_set", err_tgt_sw, 1'b1);
    idle(5);
    check("switch_err_held", err_tgt_sw, 1'b1);

    // Full FIFO 0: no pop-through while full, accept on the following cycle.
    bus.m_wready = 4'b1110;
    for (int b = 0; b < 4; b++)
      send_beat(11'h040 + IW'(b), {4{32'(b + 40)}}, 16'hFFFF, 1'b1, 2'd0);
    drive_beat(11'h044, {4{32'd44}}, 16'hABCD, 1'b1, 2'd0);
    bus.m_wready = 4'b1111;
    @(negedge clk);
    check("full_no_popthrough", bus.s_wready, 1'b0);
    @(posedge clk);
    #1;
    bus.m_wready = 4'b1110;
    @(negedge clk);
    check("full_accept_next", bus.s_wready, 1'b1);
    @(posedge clk);
    #1;
    bus.s_wvalid = 1'b0;
    @(negedge clk);
    check("full_again", bus.s_wready, 1'b0);
    @(posedge clk);
    #1;

    // Target 0 blocked and full while port 3 drains independently.
    bus.m_wready = 4'b0110;
    send_beat(11'h070, {4{32'h7000_0000}}, 16'h8001, 1'b1, 2'd3);
    send_beat(11'h071, {4{32'h7000_0001}}, 16'h8002, 1'b1, 2'd3);
    drive_beat(11'h050, {4{32'd50}}, 16'h5555, 1'b0, 2'd0);
    bus.m_wready = 4'b1110;
    idle(1);
    check("drain3_a_valid", bus.m_wvalid[3], 1'b1);
    check("drain3_a_s_wready", bus.s_wready, 1'b0);
    idle(1);
    check("drain3_b_valid", bus.m_wvalid[3], 1'b0);
    check("drain3_b_s_wready", bus.s_wready, 1'b0);
    bus.m_wready = 4'b1111;
    wait_accept();
    send_beat(11'h051, {4{32'd51}}, 16'h5555, 1'b0, 2'd0);
    send_beat(11'h052, {4{32'd52}}, 16'h5555, 1'b1, 2'd0);
    idle(8);

    // Reset in the middle of a 4-beat burst to target 1.
    bus.m_wready = 4'b1101;
    send_beat(11'h0A0, {4{32'hA0}}, 16'hFFFF, 1'b0, 2'd1);
    send_beat(11'h0A1, {4{32'hA1}}, 16'hFFFF, 1'b0, 2'd1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("midrst_m_wvalid", bus.m_wvalid, 4'b0000);
    check("midrst_burst_active", burst_active, 1'b0);
    check("midrst_err", err_tgt_sw, 1'b0);
    check("midrst_m_wdata", bus.m_wdata, '0);
    bus.m_wready = 4'b1111;
    send_beat(11'h0B0, {4{32'hB0}}, 16'h00F0, 1'b0, 2'd2);
    check("post_rst_burst_active", burst_active, 1'b1);
    send_beat(11'h0B1, {4{32'hB1}}, 16'h0F00, 1'b1, 2'd2);
    idle(4);

    // Random mix of bursts against random per-target backpressure.
    fork
      begin
        for (int k = 0; k < 60; k++) begin
          int len;
          logic [1:0] tgt;
          len = $urandom_range(1, 5);
          tgt = 2'($urandom);
          for (int b = 0; b < len; b++)
            send_beat(IW'($urandom), {$urandom, $urandom, $urandom, $urandom},
                      SW'($urandom), b == len - 1, tgt);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          bus.m_wready = 4'($urandom);
        end
      end
    join
    bus.m_wready = 4'b1111;
    idle(10);
    for (int t = 0; t < NT; t++) check($sformatf("drained_t%0d", t), exp_q[t].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
